// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with a branch-target lookup table, feeding instruction memory.
// Optional macro FETCH_CYCLE_COUNT_EN adds RUN-cycle and stall-cycle counters.
module fetch_unit #(
   parameter logic [31:0] START_PC  = 32'd0,
   parameter int          LUT_DEPTH = 16,
   parameter int          LUT_IDX_W = 4,
   parameter logic [31:0] MAX_PC    = 32'd4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 halt,
   input  logic                 take_branch,
   input  logic [LUT_IDX_W-1:0] branch_idx,
   input  logic                 lut_we,
   input  logic [LUT_IDX_W-1:0] lut_waddr,
   input  logic [31:0]          lut_wdata,
`ifdef FETCH_CYCLE_COUNT_EN
   output logic [31:0]          cycle_count,
   output logic [31:0]          stall_count,
`endif
   output logic [31:0]          current_pc,
   output logic                 running,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [31:0] lut [LUT_DEPTH];
   logic [31:0] pc_inc;
   logic        at_limit;

   assign pc_inc   = current_pc + 32'd1;
   assign at_limit = (pc_inc == MAX_PC);

`ifdef FETCH_CYCLE_COUNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         current_pc <= START_PC;
         running    <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= 32'd0;
`ifdef FETCH_CYCLE_COUNT_EN
         cycle_count <= 32'd0;
         stall_count <= 32'd0;
`endif
      end else begin
         // Non-blocking write: a same-edge branch read still sees the old entry.
         if (lut_we) lut[lut_waddr] <= lut_wdata;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RUN;
                  current_pc <= START_PC;
                  running    <= 1'b1;
                  done       <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
                  cycle_count <= 32'd0;
                  stall_count <= 32'd0;
`endif
               end
            end
            RUN: begin
`ifdef FETCH_CYCLE_COUNT_EN
               cycle_count <= sat_inc(cycle_count);
               if (stall && !halt) stall_count <= sat_inc(stall_count);
`endif
               if (halt) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (!stall) begin
                  if (take_branch) begin
                     current_pc <= lut[branch_idx];
                  end else if (at_limit) begin
                     // Runaway protection: stop at MAX_PC-1 rather than stepping onto MAX_PC.
                     state   <= DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     current_pc <= pc_inc;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a default instance plus a MAX_PC=8 instance for the runaway limit.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, start, stall, halt, take_branch, lut_we;
   logic [3:0]  branch_idx, lut_waddr;
   logic [31:0] lut_wdata;
   logic [31:0] current_pc;
   logic        running, done;

   logic        l_reset, l_start, l_zero;
   logic [3:0]  l_idx;
   logic [31:0] l_wdata;
   logic [31:0] l_pc;
   logic        l_running, l_done;

`ifdef FETCH_CYCLE_COUNT_EN
   logic [31:0] cycle_count, stall_count, l_cycle_count, l_stall_count;
`endif

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
      .take_branch(take_branch), .branch_idx(branch_idx), .lut_we(lut_we),
      .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
`ifdef FETCH_CYCLE_COUNT_EN
      .cycle_count(cycle_count), .stall_count(stall_count),
`endif
      .current_pc(current_pc), .running(running), .done(done)
   );

   fetch_unit #(.MAX_PC(32'd8)) u_lim (
      .clk(clk), .reset(l_reset), .start(l_start), .stall(l_zero), .halt(l_zero),
      .take_branch(l_zero), .branch_idx(l_idx), .lut_we(l_zero),
      .lut_waddr(l_idx), .lut_wdata(l_wdata),
`ifdef FETCH_CYCLE_COUNT_EN
      .cycle_count(l_cycle_count), .stall_count(l_stall_count),
`endif
      .current_pc(l_pc), .running(l_running), .done(l_done)
   );

   typedef struct {
      logic        lim;
      int          id;
      logic [31:0] pc;
      logic        run;
      logic        dn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step%0d got %h want %h", name, id, got, want);
      end
   endtask

   // Monitor: one expectation is popped and compared per cycle, on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.lim) begin
            check("lim_pc", e.id, l_pc, e.pc);
            check("lim_running", e.id, {31'd0, l_running}, {31'd0, e.run});
            check("lim_done", e.id, {31'd0, l_done}, {31'd0, e.dn});
         end else begin
            check("pc", e.id, current_pc, e.pc);
            check("running", e.id, {31'd0, running}, {31'd0, e.run});
            check("done", e.id, {31'd0, done}, {31'd0, e.dn});
         end
      end
   end

   task automatic push(input logic lim, input logic [31:0] pc, input logic r, input logic d);
      exp_t e;
      e.lim = lim; e.id = step_id; e.pc = pc; e.run = r; e.dn = d;
      exp_q.push_back(e);
      step_id++;
   endtask

   // One clock edge with the currently driven inputs; single-cycle pulses drop afterwards.
   task automatic cyc(input logic [31:0] pc, input logic r, input logic d);
      @(posedge clk); #1;
      push(1'b0, pc, r, d);
      start = 0; stall = 0; halt = 0; take_branch = 0; lut_we = 0;
   endtask

   task automatic cyc_l(input logic [31:0] pc, input logic r, input logic d);
      @(posedge clk); #1;
      push(1'b1, pc, r, d);
      l_start = 0;
   endtask

   initial begin
      reset = 0; start = 0; stall = 0; halt = 0; take_branch = 0; lut_we = 0;
      branch_idx = 0; lut_waddr = 0; lut_wdata = 0;
      l_reset = 0; l_start = 0; l_zero = 0; l_idx = 0; l_wdata = 0;

      // Reset state, then IDLE ignores stall/halt/branch
      cyc(0, 0, 0); cyc(0, 0, 0);
      reset = 1;
      cyc(0, 0, 0);
      stall = 1; halt = 1; take_branch = 1; branch_idx = 4'd3;
      cyc(0, 0, 0);
      lut_we = 1; lut_waddr = 4'd3; lut_wdata = 32'h40;
      cyc(0, 0, 0);

      // Start and sequential increment
      start = 1; cyc(0, 1, 0);
      for (int i = 1; i <= 5; i++) cyc(i, 1, 0);

      // Stall beats branch; then branch alone
      stall = 1; take_branch = 1; branch_idx = 4'd3;
      cyc(5, 1, 0);
      take_branch = 1; branch_idx = 4'd3;
      cyc(32'h40, 1, 0);
      cyc(32'h41, 1, 0);

      // Halt has top priority; DONE holds and ignores halt/stall
      halt = 1; take_branch = 1; stall = 1;
      cyc(32'h41, 0, 1);
      for (int i = 0; i < 10; i++) begin
         halt = i[0]; stall = ~i[0];
         cyc(32'h41, 0, 1);
      end
      start = 1; cyc(0, 1, 0);
      start = 1; cyc(1, 1, 0);

      // Same-cycle LUT write and branch read
      lut_we = 1; lut_waddr = 4'd2; lut_wdata = 32'h10;
      cyc(2, 1, 0);
      lut_we = 1; lut_waddr = 4'd2; lut_wdata = 32'h20; take_branch = 1; branch_idx = 4'd2;
      cyc(32'h10, 1, 0);
      take_branch = 1; branch_idx = 4'd2;
      cyc(32'h20, 1, 0);
      cyc(32'h21, 1, 0); cyc(32'h22, 1, 0); cyc(32'h23, 1, 0);

      // Mid-run reset with a LUT write in the same cycle
      reset = 0; lut_we = 1; lut_waddr = 4'd3; lut_wdata = 32'h99;
      cyc(0, 0, 0);
`ifdef FETCH_CYCLE_COUNT_EN
      check("cycle_count_rst", step_id, cycle_count, 32'd0);
      check("stall_count_rst", step_id, stall_count, 32'd0);
`endif
      reset = 1;
      start = 1; cyc(0, 1, 0);
      take_branch = 1; branch_idx = 4'd2; cyc(0, 1, 0);
      take_branch = 1; branch_idx = 4'd3; cyc(0, 1, 0);
      cyc(1, 1, 0);

      // Runaway limit on the MAX_PC=8 instance
      l_reset = 1;
      cyc_l(0, 0, 0);
      l_start = 1; cyc_l(0, 1, 0);
      for (int i = 1; i <= 7; i++) cyc_l(i, 1, 0);
      cyc_l(7, 0, 1);
      cyc_l(7, 0, 1);
      cyc_l(7, 0, 1);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
